// File: rtl/vga_scan_timing.sv
`timescale 1ns/1ps
// VGA raster scan: pixel enable, h/v coordinates, delayed sync/blank strobes, line/frame ticks.
// Latency: counters 1 clk after pclk_en edge; *_d outputs lag counters by PIPE_DELAY pixel enables.
// Backpressure: none; free-running raster, downstream must keep up with every pixel enable.
module vga_scan_timing #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pclk_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       valid_d,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END  = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic h_last;
    logic v_last;
    logic hsync_raw;
    logic vsync_raw;

    // Registered enable: raised as the divider reaches its last count so the
    // counters step on the CLK_DIV-th edge after reset release.
    if (CLK_DIV > 1) begin : g_div
        localparam int unsigned DW = $clog2(CLK_DIV);
        localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

        logic [DW-1:0] div_cnt;
        logic [DW-1:0] div_nxt;

        always_comb begin
            div_nxt = div_cnt + 1'b1;
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                div_cnt <= '0;
                pclk_en <= 1'b0;
            end else begin
                div_cnt <= div_nxt;
                pclk_en <= (div_nxt == DIV_LAST);
            end
        end
    end else begin : g_nodiv
        assign pclk_en = 1'b1;
    end

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pclk_en && h_last;
            frame_start <= pclk_en && h_last && v_last;
            if (pclk_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    if (v_last) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 10'd1;
                    end
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    assign valid     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hsync_raw = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    assign vsync_raw = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));

    if (PIPE_DELAY == 0) begin : g_nodly
        assign valid_d = valid;
        assign hsync_d = hsync_raw;
        assign vsync_d = vsync_raw;
    end else begin : g_dly
        logic [PIPE_DELAY-1:0] valid_pipe;
        logic [PIPE_DELAY-1:0] hsync_pipe;
        logic [PIPE_DELAY-1:0] vsync_pipe;

        // Sync stages reset high so no pulse survives a mid-frame reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_pipe <= '0;
                hsync_pipe <= '1;
                vsync_pipe <= '1;
            end else if (pclk_en) begin
                valid_pipe <= PIPE_DELAY'({valid_pipe, valid});
                hsync_pipe <= PIPE_DELAY'({hsync_pipe, hsync_raw});
                vsync_pipe <= PIPE_DELAY'({vsync_pipe, vsync_raw});
            end
        end

        assign valid_d = valid_pipe[PIPE_DELAY-1];
        assign hsync_d = hsync_pipe[PIPE_DELAY-1];
        assign vsync_d = vsync_pipe[PIPE_DELAY-1];
    end

endmodule
